// File: rtl/huffman_decode_if.sv
// huffman_decode_if: codebook load, bit-stream handshake and symbol outputs of the Huffman decoder
interface huffman_decode_if #(parameter int CW = 9, parameter int LW = 4);
   logic          tbl_wr;
   logic [3:0]    tbl_idx;
   logic [CW-1:0] tbl_code;
   logic [LW-1:0] tbl_len;
   logic          start;
   logic          stop;
   logic          bit_in;
   logic          bit_valid;
   logic          bit_ready;
   logic [3:0]    sym_out;
   logic          sym_valid;
   logic          err;
   logic          busy;
   logic [15:0]   sym_cnt;
   modport master (
      output tbl_wr, tbl_idx, tbl_code, tbl_len, start, stop, bit_in, bit_valid,
      input  bit_ready, sym_out, sym_valid, err, busy, sym_cnt
   );
   modport slave (
      input  tbl_wr, tbl_idx, tbl_code, tbl_len, start, stop, bit_in, bit_valid,
      output bit_ready, sym_out, sym_valid, err, busy, sym_cnt
   );
endinterface

// File: rtl/huffman_decode.sv
// huffman_decode: loads a (code, length) codebook and decodes a serial Huffman bitstream into symbol indices
module huffman_decode #(
   parameter int NSYM = 10,
   parameter int CW   = 9,
   parameter int LW   = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   huffman_decode_if.slave bus
);
   typedef enum logic [1:0] {IDLE, DECODE, ERROR} state_t;
   state_t        state, state_d;
   logic [CW-1:0] code_q [NSYM];
   logic [LW-1:0] len_q  [NSYM];
   logic [CW-2:0] acc;
   logic [CW-1:0] nacc, mask;
   logic [LW-1:0] acc_len, nlen;
   logic          take, hit, tbl_we, full;
   logic [3:0]    hit_idx, sym_q;
   logic          sym_v, err_q;
   logic [15:0]   cnt_q;
   // stop and start both discard a bit offered in the same cycle
   assign take   = state == DECODE && bus.bit_valid && !bus.start && !bus.stop;
   assign nacc   = {acc, bus.bit_in};
   assign nlen   = acc_len + 1'b1;
   assign mask   = ~({CW{1'b1}} << nlen);
   assign full   = nlen == LW'(CW);
   assign tbl_we = state == IDLE && bus.tbl_wr && int'(bus.tbl_idx) < NSYM;
   // descending scan so the lowest matching index wins on non-prefix-free tables
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = NSYM - 1; i >= 0; i--)
         if (len_q[i] == nlen && ((code_q[i] ^ nacc) & mask) == '0) begin
            hit     = 1'b1;
            hit_idx = 4'(i);
         end
   end
   always_comb begin
      state_d = bus.stop ? IDLE : bus.start ? DECODE : (take && !hit && full) ? ERROR : state;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_d;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int i = 0; i < NSYM; i++) begin
            code_q[i] <= '0;
            len_q[i]  <= '0;
         end
         acc     <= '0;
         acc_len <= '0;
         sym_q   <= '0;
         sym_v   <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sym_v <= take && hit;
         if (tbl_we) begin
            code_q[bus.tbl_idx] <= bus.tbl_code;
            len_q[bus.tbl_idx]  <= bus.tbl_len;
         end
         if (bus.stop) acc_len <= '0;
         else if (bus.start) begin
            acc_len <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
         end else if (take) begin
            if (hit) begin
               sym_q   <= hit_idx;
               cnt_q   <= cnt_q + 1'b1;
               acc_len <= '0;
            end else if (full) err_q <= 1'b1;
            else begin
               acc     <= nacc[CW-2:0];
               acc_len <= nlen;
            end
         end
      end
   assign bus.bit_ready = state == DECODE;
   assign bus.busy      = state != IDLE;
   assign bus.sym_out   = sym_q;
   assign bus.sym_valid = sym_v;
   assign bus.err       = err_q;
   assign bus.sym_cnt   = cnt_q;
endmodule

// File: tb/tb_huffman_decode.sv
// tb_huffman_decode: vector table and scoreboard bench for huffman_decode
module tb_huffman_decode;
   typedef struct {logic b; logic ends; logic [3:0] sym;} vec_t;
   typedef struct {logic [3:0] sym; int t;} exp_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   nchk = 0;
   int   nfail = 0;
   exp_t q[$];
   exp_t got;
   vec_t v1[9];
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   huffman_decode_if #(.CW(9), .LW(4)) bus();
   huffman_decode #(.NSYM(10), .CW(9), .LW(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      nchk++;
      if (a !== e) begin
         nfail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", n, a, e, cyc);
      end
   endtask
   task automatic load(input logic [3:0] idx, input logic [8:0] code, input logic [3:0] len);
      bus.tbl_wr = 1'b1; bus.tbl_idx = idx; bus.tbl_code = code; bus.tbl_len = len;
      @(posedge clk); #1;
      bus.tbl_wr = 1'b0;
   endtask
   task automatic pulse_start();
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask
   task automatic pulse_stop();
      bus.stop = 1'b1;
      @(posedge clk); #1;
      bus.stop = 1'b0;
   endtask
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   // offers one bit; leaves bit_valid high so callers can stream back-to-back
   task automatic send_bit(input logic b, input logic ends, input logic [3:0] s);
      int w = 0;
      bus.bit_in = b; bus.bit_valid = 1'b1;
      while (!bus.bit_ready && w < 20) begin
         @(posedge clk); #1;
         w++;
      end
      chk("bit_ready", bus.bit_ready, 1);
      if (ends) q.push_back('{sym: s, t: cyc + 1});
      @(posedge clk); #1;
   endtask
   initial begin
      v1[0] = '{1'b0, 1'b1, 4'd0};
      v1[1] = '{1'b1, 1'b0, 4'd0};
      v1[2] = '{1'b0, 1'b1, 4'd1};
      v1[3] = '{1'b1, 1'b0, 4'd0};
      v1[4] = '{1'b1, 1'b0, 4'd0};
      v1[5] = '{1'b0, 1'b1, 4'd2};
      v1[6] = '{1'b1, 1'b0, 4'd0};
      v1[7] = '{1'b1, 1'b0, 4'd0};
      v1[8] = '{1'b1, 1'b1, 4'd3};
      bus.tbl_wr = 1'b0; bus.tbl_idx = '0; bus.tbl_code = '0; bus.tbl_len = '0;
      bus.start = 1'b0; bus.stop = 1'b0; bus.bit_in = 1'b0; bus.bit_valid = 1'b0;
      idle(2);
      chk("rst_sym_out", bus.sym_out, 0);
      chk("rst_sym_valid", bus.sym_valid, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_bit_ready", bus.bit_ready, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_sym_cnt", bus.sym_cnt, 0);
      rst_n = 1'b1;
      fork
         forever begin
            @(negedge clk);
            if (rst_n && bus.sym_valid) begin
               if (q.size() == 0) begin
                  nchk++;
                  nfail++;
                  $display("FAIL unexpected_sym: got sym %0d, expected no symbol (cycle %0d)", bus.sym_out, cyc);
               end else begin
                  got = q.pop_front();
                  chk("sym_out", bus.sym_out, got.sym);
                  chk("sym_time", cyc, got.t);
               end
            end
         end
      join_none
      idle(1);
      // T1: four-symbol codebook, one pass through the vector table
      load(0, 9'b0, 1);
      load(1, 9'b10, 2);
      load(2, 9'b110, 3);
      load(3, 9'b111, 3);
      pulse_start();
      chk("t1_busy", bus.busy, 1);
      foreach (v1[i]) send_bit(v1[i].b, v1[i].ends, v1[i].sym);
      bus.bit_valid = 1'b0;
      idle(2);
      chk("t1_sym_cnt", bus.sym_cnt, 4);
      // T2: back-to-back 1-bit symbols with valid held
      for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1, 4'd0);
      bus.bit_valid = 1'b0;
      idle(2);
      chk("t2_sym_cnt", bus.sym_cnt, 8);
      // T3: no codeword ever completes on a run of ones
      pulse_stop();
      chk("t3_idle_busy", bus.busy, 0);
      load(1, 9'b0, 0);
      load(2, 9'b0, 0);
      load(3, 9'b0, 0);
      pulse_start();
      chk("t3_cnt_clear", bus.sym_cnt, 0);
      for (int i = 0; i < 9; i++) send_bit(1'b1, 1'b0, 4'd0);
      bus.bit_valid = 1'b0;
      chk("t3_err", bus.err, 1);
      chk("t3_ready_low", bus.bit_ready, 0);
      chk("t3_busy", bus.busy, 1);
      idle(2);
      chk("t3_err_held", bus.err, 1);
      pulse_start();
      chk("t3_err_clear", bus.err, 0);
      chk("t3_busy2", bus.busy, 1);
      chk("t3_ready2", bus.bit_ready, 1);
      // T4: stop drops both the partial codeword and the bit offered with it
      pulse_stop();
      load(1, 9'b10, 2);
      load(2, 9'b110, 3);
      load(3, 9'b111, 3);
      pulse_start();
      send_bit(1'b1, 1'b0, 4'd0);
      send_bit(1'b1, 1'b0, 4'd0);
      bus.bit_in = 1'b1; bus.bit_valid = 1'b1; bus.stop = 1'b1;
      @(posedge clk); #1;
      bus.stop = 1'b0; bus.bit_valid = 1'b0;
      chk("t4_busy", bus.busy, 0);
      chk("t4_no_sym", bus.sym_valid, 0);
      pulse_start();
      send_bit(1'b0, 1'b1, 4'd0);
      bus.bit_valid = 1'b0;
      idle(2);
      // T5: table write ignored in DECODE, out-of-range index ignored, lowest index wins
      load(1, 9'b0, 1);
      send_bit(1'b1, 1'b0, 4'd0);
      send_bit(1'b0, 1'b1, 4'd1);
      bus.bit_valid = 1'b0;
      idle(2);
      pulse_stop();
      load(12, 9'b1, 1);
      load(5, 9'b0, 1);
      pulse_start();
      send_bit(1'b0, 1'b1, 4'd0);
      send_bit(1'b1, 1'b0, 4'd0);
      send_bit(1'b0, 1'b1, 4'd1);
      bus.bit_valid = 1'b0;
      idle(2);
      chk("t5_sym_cnt", bus.sym_cnt, 2);
      // T6: asynchronous reset mid-codeword wipes the codebook
      send_bit(1'b1, 1'b0, 4'd0);
      bus.bit_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("t6_sym_out", bus.sym_out, 0);
      chk("t6_sym_valid", bus.sym_valid, 0);
      chk("t6_err", bus.err, 0);
      chk("t6_bit_ready", bus.bit_ready, 0);
      chk("t6_busy", bus.busy, 0);
      chk("t6_sym_cnt", bus.sym_cnt, 0);
      idle(2);
      rst_n = 1'b1;
      pulse_start();
      for (int i = 0; i < 9; i++) send_bit(1'b0, 1'b0, 4'd0);
      bus.bit_valid = 1'b0;
      chk("t6_err_after", bus.err, 1);
      chk("t6_ready_after", bus.bit_ready, 0);
      idle(3);
      chk("pending_syms", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end
endmodule
